// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT stage sequencer: FSM encoding,
// elaboration-time helpers and the Q-format rounding/saturation used by the twiddle table.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    localparam real FFT_TWO_PI = 6.283185307179586;

    // Ceiling log2, usable in constant expressions.
    function automatic int fft_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Read-to-write distance: one cycle of RAM read latency plus the butterfly pipeline.
    function automatic int fft_dly(input int bf_lat);
        return 1 + bf_lat;
    endfunction

    // Round a real in [-1, 1] to signed Q1.(w-1) with symmetric saturation at +/-(2^(w-1)-1).
    function automatic int fft_q_sat(input real x, input int w);
        int  full;
        real scaled;
        int  r;
        full   = (1 << (w - 1)) - 1;
        scaled = x * real'(full);
        if (scaled >= 0.0) r = $rtoi(scaled + 0.5);
        else               r = -$rtoi(0.5 - scaled);
        if (r > full)       r = full;
        else if (r < -full) r = -full;
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Control/address bundle between the FFT sequencer and its loader, RAM and butterfly.
interface fft_stage_ctrl_if #(
    parameter int L_max = 3,
    parameter int TW_W  = 16
);
    logic                    initial_flag;
    logic                    inverse;
    logic                    wr_en;
    logic [L_max-1:0]        wr_add1;
    logic [L_max-1:0]        wr_add2;
    logic                    rd_en;
    logic [L_max-1:0]        rd_add1;
    logic [L_max-1:0]        rd_add2;
    logic signed [TW_W-1:0]  factor_re;
    logic signed [TW_W-1:0]  factor_im;
    logic                    en_multi;
    logic                    busy;
    logic                    flag_fftfinish;

    // Sequencer side.
    modport master (
        input  initial_flag, inverse,
        output wr_en, wr_add1, wr_add2, rd_en, rd_add1, rd_add2,
               factor_re, factor_im, en_multi, busy, flag_fftfinish
    );

    // Loader / datapath side.
    modport slave (
        output initial_flag, inverse,
        input  wr_en, wr_add1, wr_add2, rd_en, rd_add1, rd_add2,
               factor_re, factor_im, en_multi, busy, flag_fftfinish
    );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Twiddle table W^t = cos(2*pi*t/N) - j*sin(2*pi*t/N), t = 0..N/2-1, built at elaboration.
// One-cycle registered read so the coefficient lines up with RAM read data.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N    = 8,
    parameter int AW   = 2,
    parameter int TW_W = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [AW-1:0]          addr_i,
    output logic signed [TW_W-1:0] re_o,
    output logic signed [TW_W-1:0] im_o
);
    logic signed [TW_W-1:0] re_tab [N/2];
    logic signed [TW_W-1:0] im_tab [N/2];
    logic signed [TW_W-1:0] re_q;
    logic signed [TW_W-1:0] im_q;

    for (genvar k = 0; k < N/2; k++) begin : g_tab
        localparam real ANG = FFT_TWO_PI * real'(k) / real'(N);
        assign re_tab[k] = TW_W'(fft_q_sat($cos(ANG), TW_W));
        assign im_tab[k] = TW_W'(fft_q_sat(-$sin(ANG), TW_W));
    end

    // Registered lookup; holds the last coefficient while no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en_i) begin
            re_q <= re_tab[addr_i];
            im_q <= im_tab[addr_i];
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;
endmodule

// File: rtl/fft_stage_ctrl.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT over one dual-port RAM.
// Issues N/2 butterfly reads per stage, drains the butterfly pipeline between stages
// so stage s+1 never reads a location stage s has not yet written back.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N      = 8,
    parameter int L_max  = 3,
    parameter int TW_W   = 16,
    parameter int BF_LAT = 2
)(
    input  logic              clk,
    input  logic              rst,
    fft_stage_ctrl_if.master  bus
);
    localparam int JW  = L_max - 1;
    localparam int SW  = fft_clog2(L_max + 1);
    localparam int DLY = fft_dly(BF_LAT);
    localparam int DW  = fft_clog2(DLY + 1);
    localparam int PW  = 1 + 2 * L_max;

    if (L_max != fft_clog2(N) || N < 4 || N > 4096 || BF_LAT < 1 || BF_LAT > 8) begin : g_bad_param
        $error("fft_stage_ctrl: N must be a power of two in 4..4096 with L_max = clog2(N), BF_LAT in 1..8");
    end

    fft_state_t              state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic [SW-1:0]           s_q, s_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic                    inv_q, inv_d;

    logic                    rd_en;
    logic [L_max-1:0]        add1, add2;
    logic [JW-1:0]           low_mask, j_low, tw_idx;
    logic [L_max-1:0]        pipe_q [DLY];
    logic [PW-1:0]           wpipe_q [DLY];
    logic                    en_multi_q;
    logic                    inv_rd_q;
    logic signed [TW_W-1:0]  rom_re, rom_im;

    // State and counter registers; reset abandons any transform in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            s_q     <= '0;
            dcnt_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            s_q     <= s_d;
            dcnt_q  <= dcnt_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state: walk butterflies, then hold DLY cycles so the last write lands before the next stage reads.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        s_d     = s_q;
        dcnt_d  = dcnt_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.initial_flag) begin
                    state_d = ST_READ;
                    j_d     = '0;
                    s_d     = '0;
                    inv_d   = bus.inverse;
                end
            end
            ST_READ: begin
                if (j_q == JW'(N/2 - 1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DW'(DLY - 1)) begin
                    if (s_q == SW'(L_max - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        s_d     = s_q + SW'(1);
                        j_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Butterfly addressing: A = (j/h)*2h + j%h, B = A + h, twiddle t = (j%h) << (L_max-1-s).
    always_comb begin
        low_mask = (JW'(1) << s_q) - JW'(1);
        j_low    = j_q & low_mask;
        add1     = (({1'b0, j_q} >> s_q) << (s_q + SW'(1))) | {1'b0, j_low};
        add2     = add1 | (L_max'(1) << s_q);
        tw_idx   = j_low << (SW'(JW) - s_q);
    end

    assign rd_en              = (state_q == ST_READ);
    assign bus.rd_en          = rd_en;
    assign bus.rd_add1        = rd_en ? add1 : '0;
    assign bus.rd_add2        = rd_en ? add2 : '0;
    assign bus.busy           = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign bus.flag_fftfinish = (state_q == ST_DONE);

    // Write-back path: {rd_en, rd_add1, rd_add2} delayed DLY cycles to meet the butterfly result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) wpipe_q[i] <= '0;
        end else begin
            wpipe_q[0] <= {rd_en, bus.rd_add1, bus.rd_add2};
            for (int i = 1; i < DLY; i++) wpipe_q[i] <= wpipe_q[i-1];
        end
    end

    assign {bus.wr_en, bus.wr_add1, bus.wr_add2} = wpipe_q[DLY-1];

    // Butterfly valid and the inverse flag of the read it belongs to, one cycle behind the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_multi_q <= 1'b0;
            inv_rd_q   <= 1'b0;
        end else begin
            en_multi_q <= rd_en;
            if (rd_en) inv_rd_q <= inv_q;
        end
    end

    fft_twiddle_rom #(
        .N    (N),
        .AW   (JW),
        .TW_W (TW_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en_i   (rd_en),
        .addr_i (tw_idx),
        .re_o   (rom_re),
        .im_o   (rom_im)
    );

    // Conjugation for the inverse transform; symmetric saturation makes the negation overflow-free.
    assign bus.en_multi  = en_multi_q;
    assign bus.factor_re = rom_re;
    assign bus.factor_im = inv_rd_q ? -rom_im : rom_im;

    // Delayed copy of the write address, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= bus.wr_add1;
            for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: 8-point forward/inverse runs, restart/reset behaviour,
// and a 16-point run with BF_LAT=1 for latency and stage-boundary spacing.
module tb_fft_stage_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.L_max(3), .TW_W(16)) bus ();
    fft_stage_ctrl_if #(.L_max(4), .TW_W(16)) bus16 ();

    fft_stage_ctrl #(.N(8), .L_max(3), .TW_W(16), .BF_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fft_stage_ctrl #(.N(16), .L_max(4), .TW_W(16), .BF_LAT(1)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed 8-point read pairs and twiddles, stage-major, four butterflies per stage.
    int a1_t [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int a2_t [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int re_t [12] = '{32767, 32767, 32767, 32767,  32767, 0, 32767, 0,  32767, 23170, 0, -23170};
    int im_t [12] = '{0, 0, 0, 0,  0, -32767, 0, -32767,  0, -23170, -32767, -23170};

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Read k of the 8-point run happens in cycle 1+7*stage+j (4 reads + 3 drain cycles per stage).
    function automatic int rd_idx(input int c);
        for (int s = 0; s < 3; s++)
            if (c >= 1 + 7*s && c <= 4 + 7*s) return 4*s + (c - 1 - 7*s);
        return -1;
    endfunction

    task automatic check_idle8(input string tag);
        check_val({tag, " rd_en"},    int'(bus.rd_en), 0);
        check_val({tag, " wr_en"},    int'(bus.wr_en), 0);
        check_val({tag, " en_multi"}, int'(bus.en_multi), 0);
        check_val({tag, " busy"},     int'(bus.busy), 0);
        check_val({tag, " finish"},   int'(bus.flag_fftfinish), 0);
    endtask

    task automatic check_cycle8(input int c, input bit inv);
        int k, kw, km;
        k  = rd_idx(c);
        kw = rd_idx(c - 3);
        km = rd_idx(c - 1);
        check_val($sformatf("rd_en@%0d", c), int'(bus.rd_en), int'(k >= 0));
        if (k >= 0) begin
            check_val($sformatf("rd_add1@%0d", c), int'(bus.rd_add1), a1_t[k]);
            check_val($sformatf("rd_add2@%0d", c), int'(bus.rd_add2), a2_t[k]);
        end
        check_val($sformatf("wr_en@%0d", c), int'(bus.wr_en), int'(kw >= 0));
        if (kw >= 0) begin
            check_val($sformatf("wr_add1@%0d", c), int'(bus.wr_add1), a1_t[kw]);
            check_val($sformatf("wr_add2@%0d", c), int'(bus.wr_add2), a2_t[kw]);
        end
        check_val($sformatf("en_multi@%0d", c), int'(bus.en_multi), int'(km >= 0));
        if (km >= 0) begin
            check_val($sformatf("factor_re@%0d", c), int'(bus.factor_re), re_t[km]);
            check_val($sformatf("factor_im@%0d", c), int'(bus.factor_im), inv ? -im_t[km] : im_t[km]);
        end
        if (c >= 23) begin
            check_val($sformatf("hold_re@%0d", c), int'(bus.factor_re), -23170);
            check_val($sformatf("hold_im@%0d", c), int'(bus.factor_im), inv ? 23170 : -23170);
        end
        check_val($sformatf("busy@%0d", c), int'(bus.busy), int'(c >= 1 && c <= 21));
        check_val($sformatf("finish@%0d", c), int'(bus.flag_fftfinish), int'(c == 22));
    endtask

    // Start pulse sampled at edge 0; inverse is then flipped to show it is latched, not followed.
    task automatic start8(input bit inv);
        @(negedge clk);
        bus.initial_flag = 1'b1;
        bus.inverse      = inv;
        @(posedge clk);
        #1;
        bus.initial_flag = 1'b0;
        bus.inverse      = ~inv;
    endtask

    // Cycles 1..last_c of an 8-point run; optional extra start pulse issued in cycle pulse_c.
    task automatic run8(input bit inv, input int last_c, input int pulse_c);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            if (c == pulse_c + 1) bus.initial_flag = 1'b0;
            check_cycle8(c, inv);
            if (c == pulse_c) bus.initial_flag = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.initial_flag   = 1'b0;
        bus.inverse        = 1'b0;
        bus16.initial_flag = 1'b0;
        bus16.inverse      = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle8("reset");
        check_val("reset factor_re", int'(bus.factor_re), 0);
        check_val("reset factor_im", int'(bus.factor_im), 0);
        check_val("reset16 busy", int'(bus16.busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle8("idle");

        // Forward 8-point transform.
        start8(1'b0);
        run8(1'b0, 24, -1);

        // Inverse run; a start pulse in the DONE cycle must not relaunch.
        start8(1'b1);
        run8(1'b1, 24, 22);

        // Start pulse while busy is ignored, then asynchronous reset mid-transform.
        start8(1'b0);
        run8(1'b0, 12, 10);
        rst = 1'b0;
        #1;
        check_idle8("async reset");
        check_val("async reset rd_add1",   int'(bus.rd_add1), 0);
        check_val("async reset rd_add2",   int'(bus.rd_add2), 0);
        check_val("async reset wr_add1",   int'(bus.wr_add1), 0);
        check_val("async reset wr_add2",   int'(bus.wr_add2), 0);
        check_val("async reset factor_re", int'(bus.factor_re), 0);
        check_val("async reset factor_im", int'(bus.factor_im), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle8($sformatf("in reset %0d", i));
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle8($sformatf("after reset %0d", i));
        end
        start8(1'b0);
        run8(1'b0, 24, -1);

        // 16-point, BF_LAT=1: DLY=2, finish at 4*(8+2)+1 = 41.
        begin
            int  fin_c, rises, n_rd, n_wr;
            bit  prev_rd, prev_wr;
            fin_c = -1; rises = 0; n_rd = 0; n_wr = 0;
            prev_rd = 1'b0; prev_wr = 1'b0;
            @(negedge clk);
            bus16.initial_flag = 1'b1;
            @(posedge clk);
            #1;
            bus16.initial_flag = 1'b0;
            for (int c = 1; c <= 45; c++) begin
                @(negedge clk);
                if (bus16.rd_en && !prev_rd) begin
                    if (rises > 0) begin
                        check_val($sformatf("n16 wr before rd@%0d", c), int'(prev_wr), 1);
                        check_val($sformatf("n16 no wr at rd@%0d", c), int'(bus16.wr_en), 0);
                    end
                    rises++;
                end
                if (bus16.rd_en) n_rd++;
                if (bus16.wr_en) n_wr++;
                if (bus16.flag_fftfinish) begin
                    if (fin_c < 0) fin_c = c;
                    check_val($sformatf("n16 busy at finish@%0d", c), int'(bus16.busy), 0);
                end
                if (c == 31) begin
                    check_val("n16 rd_add1@31", int'(bus16.rd_add1), 0);
                    check_val("n16 rd_add2@31", int'(bus16.rd_add2), 8);
                end
                if (c == 33) begin
                    check_val("n16 rd_add1@33", int'(bus16.rd_add1), 2);
                    check_val("n16 rd_add2@33", int'(bus16.rd_add2), 10);
                end
                if (c == 34) begin
                    check_val("n16 factor_re@34", int'(bus16.factor_re), 23170);
                    check_val("n16 factor_im@34", int'(bus16.factor_im), -23170);
                end
                if (c == 35) begin
                    check_val("n16 rd_add1@35", int'(bus16.rd_add1), 4);
                    check_val("n16 rd_add2@35", int'(bus16.rd_add2), 12);
                end
                if (c == 36) begin
                    check_val("n16 factor_re@36", int'(bus16.factor_re), 0);
                    check_val("n16 factor_im@36", int'(bus16.factor_im), -32767);
                end
                prev_rd = bus16.rd_en;
                prev_wr = bus16.wr_en;
            end
            check_val("n16 finish cycle", fin_c, 41);
            check_val("n16 stage starts", rises, 4);
            check_val("n16 read count", n_rd, 32);
            check_val("n16 write count", n_wr, 32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
